adder_kernel_ctrl: RTL and testbench
====================================

// Module: adder_kernel_ctrl
// PURPOSE
//  Sequencer for the AdderNet L1 kernel array (NDATA lanes of |if-w| units).
//  On start, streams NPASS feature/weight vector pairs from the IF and W buffers into the kernel.
//  Sums every lane magnitude over all passes and counts lanes whose kernel sign bit = 1.
//  Returns the AdderNet output -(sum|if-w|) with a valid/ready handshake. Sits between the layer scheduler and the Kernel.
// PARAMETERS
//  NBIT    8   bits per lane element (matches kernel NBIT)
//  NDATA   9   lanes per kernel pass (matches kernel NDATA)
//  ADDR_W  10  buffer address width
//  PASS_W  8   width of pass count
//  ACC_W   NBIT+$clog2(NDATA)+PASS_W   magnitude accumulator width (cannot overflow)
// PORTS
//  i_clk      in   1            clock, all state on rising edge
//  i_rst      in   1            synchronous active-high reset
//  i_start    in   1            start pulse, accepted only in IDLE
//  i_npass    in   PASS_W       number of vector passes, sampled at accepted start
//  i_base_if  in   ADDR_W       IF buffer start address, sampled at start
//  i_base_w   in   ADDR_W       W buffer start address, sampled at start
//  o_rd_en    out  1            buffer read enable (both buffers)
//  o_if_addr  out  ADDR_W       IF buffer read address
//  o_w_addr   out  ADDR_W       W buffer read address
//  i_if_data  in   NBIT*NDATA   IF read data, valid 1 cycle after o_rd_en
//  i_w_data   in   NBIT*NDATA   W read data, valid 1 cycle after o_rd_en
//  o_k_if     out  NBIT*NDATA   to kernel i_if (combinational pass-through of i_if_data)
//  o_k_w      out  NBIT*NDATA   to kernel i_w (combinational pass-through of i_w_data)
//  i_k_r      in   NBIT*NDATA   kernel per-lane magnitude |if-w|
//  i_k_sign   in   NDATA        kernel per-lane sign
//  o_busy     out  1            high in RUN/DRAIN/DONE
//  o_valid    out  1            result valid (DONE state)
//  i_ready    in   1            consumer accepts result
//  o_result   out  ACC_W+1      two's complement -(sum of magnitudes)
//  o_nsign    out  NDATA_W      count of sign=1 lanes, NDATA_W = $clog2(NDATA*2^PASS_W+1)
// BEHAVIOUR
//  Reset: state=IDLE. o_rd_en, o_busy and o_valid = 0. o_result, o_nsign, accumulators and addresses = 0.
//  FSM: IDLE -> RUN on i_start.
//    i_npass=0 goes to DONE directly with result 0 and nsign 0 (o_rd_en never asserted).
//  RUN: o_rd_en=1 for exactly npass consecutive cycles, no gaps.
//    Addresses start at the bases and increment by 1 per cycle, wrapping mod 2^ADDR_W.
//    Goes to DRAIN after the last address.
//  Accumulate stage: in the cycle after each o_rd_en (rd_d1), the kernel output is combinational from the read data.
//    acc += sum over lanes of i_k_r (unsigned). nsign += popcount(i_k_sign).
//    Update happens only when rd_d1=1.
//  DRAIN: one cycle; the last pass is accumulated here. Then DONE.
//  DONE: o_valid=1, o_result=-acc, o_nsign held stable until i_valid&&i_ready (i_ready may already be high).
//    On handshake: next state is IDLE, o_valid drops, accumulators clear.
//  Latency: start at cycle 0 gives first o_rd_en at cycle 1 and o_valid at cycle npass+2 (npass>0), or at cycle 1 (npass=0).
//  i_start while busy (incl. DONE handshake cycle) is ignored; not queued.
//  Inputs i_npass and the bases are only sampled at an accepted start; later changes have no effect.
//  i_rst mid-run: next cycle is IDLE with all outputs at reset values; partial result discarded.
//  o_k_if/o_k_w carry buffer data unconditionally; the kernel is combinational, so no gating is needed.
// TESTING
//  Reset: hold i_rst 2 cycles mid-RUN -> next cycle o_busy=0, o_rd_en=0, o_valid=0, o_result=0.
//  npass=3, all if=10, w=7 (NDATA=9) -> addr base..base+2; o_valid at cycle 5; o_result=-81; o_nsign=0.
//  npass=1, if lanes=0, w lanes=255 -> o_result=-2295, o_nsign=9.
//  npass=0 -> o_valid at cycle 1, o_result=0, no o_rd_en.
//  Base 1022, npass=4, ADDR_W=10 -> addresses 1022,1023,0,1.
//  i_ready low 5 cycles in DONE -> o_valid/o_result stable; i_start during RUN/DONE ignored; new start after handshake runs clean.

Source files
------------

// File: rtl/adder_kernel_ctrl.sv
// Sequencer for the AdderNet L1 kernel array: streams NPASS IF/W vector pairs
// into the kernel, accumulates lane magnitudes and sign counts, returns -(sum).

module adder_kernel_lane #(
    parameter int NBIT   = 8,
    parameter int LSUM_W = 12
) (
    input  logic              en,
    input  logic [NBIT-1:0]   mag,
    input  logic              sign,
    output logic [LSUM_W-1:0] mag_ext,
    output logic              sign_q
);
    assign mag_ext = en ? LSUM_W'(mag) : '0;
    assign sign_q  = en & sign;
endmodule

module adder_kernel_ctrl #(
    parameter int NBIT     = 8,
    parameter int NDATA    = 9,
    parameter int ADDR_W   = 10,
    parameter int PASS_W   = 8,
    localparam int ACC_W   = NBIT + $clog2(NDATA) + PASS_W,
    localparam int NDATA_W = $clog2(NDATA * (2 ** PASS_W) + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [PASS_W-1:0]     i_npass,
    input  logic [ADDR_W-1:0]     i_base_if,
    input  logic [ADDR_W-1:0]     i_base_w,
    output logic                  o_rd_en,
    output logic [ADDR_W-1:0]     o_if_addr,
    output logic [ADDR_W-1:0]     o_w_addr,
    input  logic [NBIT*NDATA-1:0] i_if_data,
    input  logic [NBIT*NDATA-1:0] i_w_data,
    output logic [NBIT*NDATA-1:0] o_k_if,
    output logic [NBIT*NDATA-1:0] o_k_w,
    input  logic [NBIT*NDATA-1:0] i_k_r,
    input  logic [NDATA-1:0]      i_k_sign,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ACC_W:0]        o_result,
    output logic [NDATA_W-1:0]    o_nsign
);
    localparam int LSUM_W = NBIT + $clog2(NDATA);
    localparam int CNT_W  = $clog2(NDATA + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [PASS_W-1:0] pass_cnt;
    logic              rd_d1;
    logic [ACC_W-1:0]  acc;
    logic [NDATA_W-1:0] nsign;

    logic [NDATA-1:0][LSUM_W-1:0] lane_mag;
    logic [NDATA-1:0]             lane_sign;
    logic [LSUM_W-1:0]            lsum;
    logic [CNT_W-1:0]             lcnt;

    // Kernel is combinational, so read data goes straight through.
    assign o_k_if = i_if_data;
    assign o_k_w  = i_w_data;

    // Lane contributions are zeroed unless this cycle carries read data.
    for (genvar g = 0; g < NDATA; g++) begin : g_lane
        adder_kernel_lane #(.NBIT(NBIT), .LSUM_W(LSUM_W)) u_lane (
            .en      (rd_d1),
            .mag     (i_k_r[g*NBIT +: NBIT]),
            .sign    (i_k_sign[g]),
            .mag_ext (lane_mag[g]),
            .sign_q  (lane_sign[g])
        );
    end

    always_comb begin
        lsum = '0;
        lcnt = '0;
        for (int i = 0; i < NDATA; i++) begin
            lsum = lsum + lane_mag[i];
            lcnt = lcnt + CNT_W'(lane_sign[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            pass_cnt  <= '0;
            o_if_addr <= '0;
            o_w_addr  <= '0;
            rd_d1     <= 1'b0;
            acc       <= '0;
            nsign     <= '0;
        end else begin
            rd_d1 <= (state == S_RUN);
            if (rd_d1) begin
                acc   <= acc + ACC_W'(lsum);
                nsign <= nsign + NDATA_W'(lcnt);
            end
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_if_addr <= i_base_if;
                        o_w_addr  <= i_base_w;
                        pass_cnt  <= i_npass;
                        state     <= (i_npass == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    o_if_addr <= o_if_addr + 1'b1;
                    o_w_addr  <= o_w_addr + 1'b1;
                    pass_cnt  <= pass_cnt - 1'b1;
                    if (pass_cnt == PASS_W'(1)) state <= S_DRAIN;
                end
                S_DRAIN: state <= S_DONE;
                S_DONE: begin
                    if (i_ready) begin
                        state <= S_IDLE;
                        acc   <= '0;
                        nsign <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en  = (state == S_RUN);
    assign o_busy   = (state != S_IDLE);
    assign o_valid  = (state == S_DONE);
    assign o_result = -{1'b0, acc};
    assign o_nsign  = nsign;
endmodule

// File: tb/tb_adder_kernel_ctrl.sv
// Bench for adder_kernel_ctrl: random buffer contents and jobs, a timeline
// reference model checked every cycle, and a few literal-pinned scenarios.

module tb_adder_kernel_ctrl;
    localparam int NBIT = 8, NDATA = 9, ADDR_W = 10, PASS_W = 8;
    localparam int DW = NBIT * NDATA;
    localparam int ACC_W = NBIT + $clog2(NDATA) + PASS_W;
    localparam int NDATA_W = $clog2(NDATA * (2 ** PASS_W) + 1);
    localparam int AMOD = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic i_rst, i_start, i_ready;
    logic [PASS_W-1:0] i_npass;
    logic [ADDR_W-1:0] i_base_if, i_base_w;
    logic o_rd_en, o_busy, o_valid;
    logic [ADDR_W-1:0] o_if_addr, o_w_addr;
    logic [DW-1:0] if_data, w_data, o_k_if, o_k_w, k_r;
    logic [NDATA-1:0] k_sign;
    logic [ACC_W:0] o_result;
    logic [NDATA_W-1:0] o_nsign;

    logic [DW-1:0] IFM [AMOD];
    logic [DW-1:0] WM  [AMOD];

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    adder_kernel_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_npass(i_npass),
        .i_base_if(i_base_if), .i_base_w(i_base_w), .o_rd_en(o_rd_en),
        .o_if_addr(o_if_addr), .o_w_addr(o_w_addr), .i_if_data(if_data),
        .i_w_data(w_data), .o_k_if(o_k_if), .o_k_w(o_k_w), .i_k_r(k_r),
        .i_k_sign(k_sign), .o_busy(o_busy), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_nsign(o_nsign)
    );

    // Buffers: one-cycle read latency; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (o_rd_en) begin
            if_data <= IFM[o_if_addr];
            w_data  <= WM[o_w_addr];
        end else begin
            if_data <= DW'({$urandom, $urandom, $urandom});
            w_data  <= DW'({$urandom, $urandom, $urandom});
        end
    end

    // Kernel: per-lane |if-w| with sign set when if < w.
    always_comb begin
        k_r = '0;
        k_sign = '0;
        for (int l = 0; l < NDATA; l++) begin
            logic [NBIT-1:0] a, b;
            a = o_k_if[l*NBIT +: NBIT];
            b = o_k_w[l*NBIT +: NBIT];
            k_r[l*NBIT +: NBIT] = (a > b) ? a - b : b - a;
            k_sign[l] = (a < b);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void calc(input int np, input int bif, input int bw,
                                 output int s, output int ns);
        s = 0;
        ns = 0;
        for (int p = 0; p < np; p++) begin
            for (int l = 0; l < NDATA; l++) begin
                int a, b;
                a = int'(IFM[(bif + p) % AMOD][l*NBIT +: NBIT]);
                b = int'(WM[(bw + p) % AMOD][l*NBIT +: NBIT]);
                s += (a > b) ? a - b : b - a;
                if (a < b) ns++;
            end
        end
    endfunction

    // Timeline model: k counts cycles since the accepted start.
    bit m_known = 0, m_busy = 0, m_after_rst = 0;
    int m_k = 0, m_np = 0, m_bif = 0, m_bw = 0, m_v = 0;
    logic [ACC_W:0] m_res = '0;
    int m_ns = 0;

    always @(negedge clk) begin
        bit exp_rd, exp_vld;
        int s, ns;
        if (m_known) begin
            exp_rd  = m_busy && m_np > 0 && m_k >= 1 && m_k <= m_np;
            exp_vld = m_busy && m_k >= m_v;
            chk("busy", longint'(o_busy), longint'(m_busy));
            chk("rd_en", longint'(o_rd_en), longint'(exp_rd));
            chk("valid", longint'(o_valid), longint'(exp_vld));
            if (exp_rd) begin
                chk("if_addr", longint'(o_if_addr), longint'((m_bif + m_k - 1) % AMOD));
                chk("w_addr", longint'(o_w_addr), longint'((m_bw + m_k - 1) % AMOD));
            end
            if (exp_vld) begin
                chk("result", longint'(o_result), longint'(m_res));
                chk("nsign", longint'(o_nsign), longint'(m_ns));
            end
            if (m_after_rst) begin
                chk("rst_result", longint'(o_result), 0);
                chk("rst_nsign", longint'(o_nsign), 0);
            end
            chk("k_pass", longint'(o_k_if == if_data && o_k_w == w_data), 1);
        end
        if (i_rst) begin
            m_known <= 1;
            m_busy <= 0;
            m_after_rst <= 1;
        end else if (m_known) begin
            if (!m_busy) begin
                if (i_start) begin
                    calc(int'(i_npass), int'(i_base_if), int'(i_base_w), s, ns);
                    m_busy <= 1;
                    m_k <= 1;
                    m_np <= int'(i_npass);
                    m_bif <= int'(i_base_if);
                    m_bw <= int'(i_base_w);
                    m_v <= (i_npass == 0) ? 1 : int'(i_npass) + 2;
                    m_res <= (ACC_W+1)'(-s);
                    m_ns <= ns;
                    m_after_rst <= 0;
                end
            end else if (m_k >= m_v && i_ready) begin
                m_busy <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    int addr_q[$];

    task automatic run_job(input int np, input int bif, input int bw, input int delay,
                           input bit lit, input int lit_res, input int lit_ns, input bit noise);
        int n;
        addr_q.delete();
        @(posedge clk); #1;
        i_start = 1;
        i_npass = PASS_W'(np);
        i_base_if = ADDR_W'(bif);
        i_base_w = ADDR_W'(bw);
        i_ready = (delay == 0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1 || !noise) begin
                i_start = 0;
            end else begin
                i_start = ($urandom_range(0, 3) == 0);
                i_npass = PASS_W'($urandom_range(0, 255));
                i_base_if = ADDR_W'($urandom);
                i_base_w = ADDR_W'($urandom);
            end
            if (o_rd_en) addr_q.push_back(int'(o_if_addr));
        end while (!o_valid && n < 400);
        if (!o_valid) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("latency", longint'(n), longint'((np == 0) ? 1 : np + 2));
        if (lit) begin
            chk("lit_result", longint'($signed(o_result)), longint'(lit_res));
            chk("lit_nsign", longint'(o_nsign), longint'(lit_ns));
        end
        if (delay > 0) begin
            repeat (delay) begin
                @(posedge clk); #1;
                if (noise) i_start = ($urandom_range(0, 1) == 0);
            end
            i_ready = 1;
        end
        @(posedge clk); #1;
        i_ready = 0;
        i_start = 0;
        chk("handshake_idle", longint'(o_busy), 0);
    endtask

    initial begin
        i_rst = 1; i_start = 0; i_ready = 0; i_npass = '0;
        i_base_if = '0; i_base_w = '0;
        for (int a = 0; a < AMOD; a++) begin
            IFM[a] = DW'({$urandom, $urandom, $urandom});
            WM[a]  = DW'({$urandom, $urandom, $urandom});
        end
        repeat (3) @(posedge clk);
        #1 i_rst = 0;
        @(posedge clk); #1;
        chk("reset_busy", longint'(o_busy), 0);
        chk("reset_rd_en", longint'(o_rd_en), 0);
        chk("reset_valid", longint'(o_valid), 0);
        chk("reset_result", longint'(o_result), 0);

        for (int p = 0; p < 3; p++) begin
            for (int l = 0; l < NDATA; l++) begin
                IFM[100 + p][l*NBIT +: NBIT] = 8'd10;
                WM[200 + p][l*NBIT +: NBIT]  = 8'd7;
            end
        end
        run_job(3, 100, 200, 0, 1, -81, 0, 0);
        chk("addr_cnt3", longint'(addr_q.size()), 3);
        if (addr_q.size() == 3) chk("addr_last3", longint'(addr_q[2]), 102);

        IFM[5] = '0;
        WM[600] = '1;
        run_job(1, 5, 600, 2, 1, -2295, 9, 0);

        run_job(0, 7, 9, 1, 1, 0, 0, 0);
        chk("npass0_no_rd", longint'(addr_q.size()), 0);

        run_job(4, 1022, 1022, 5, 0, 0, 0, 1);
        chk("wrap_cnt", longint'(addr_q.size()), 4);
        if (addr_q.size() == 4) begin
            chk("wrap_a0", longint'(addr_q[0]), 1022);
            chk("wrap_a1", longint'(addr_q[1]), 1023);
            chk("wrap_a2", longint'(addr_q[2]), 0);
            chk("wrap_a3", longint'(addr_q[3]), 1);
        end

        // Reset in the middle of a run discards the partial result.
        @(posedge clk); #1;
        i_start = 1; i_npass = 8'd30; i_base_if = 10'd50; i_base_w = 10'd60;
        @(posedge clk); #1;
        i_start = 0;
        repeat (5) @(posedge clk);
        #1 i_rst = 1;
        repeat (2) @(posedge clk);
        #1 i_rst = 0;
        chk("midrst_busy", longint'(o_busy), 0);
        chk("midrst_rd_en", longint'(o_rd_en), 0);
        chk("midrst_valid", longint'(o_valid), 0);
        chk("midrst_result", longint'(o_result), 0);

        run_job(2, 300, 301, 0, 0, 0, 0, 0);

        for (int j = 0; j < 40; j++) begin
            run_job(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
                    int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                    int'($urandom_range(0, 5)), 0, 0, 0, bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
